normalize_pipe: RTL and testbench

NORMALIZE_PIPE -- requirements
Module: normalize_pipe

---
 rtl/fma_norm_pkg.sv | 22 ++
 rtl/norm_lead_corr.sv | 36 +++
 rtl/normalize_pipe.sv | 197 +++++++++++++++++++
 tb/tb_normalize_pipe.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fma_norm_pkg.sv
// Shared definitions for the FMA normalization pipeline.
//   calc_pre_w   : width of the adder output entering normalization
//   calc_out_w   : width of the normalized significand window (hidden bit + G/R/S room)
//   EXP_ZERO     : exponent value driven on zero results and on underflow clamp
//   exp_sat_max  : all-ones exponent used as the overflow clamp and threshold
package fma_norm_pkg;

  localparam int EXP_ZERO = 0;

  function automatic int calc_pre_w(input int sig_w);
    return 3 * (sig_w + 1) + 8;
  endfunction

  function automatic int calc_out_w(input int sig_w);
    return sig_w + 4;
  endfunction

  function automatic int exp_sat_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/norm_lead_corr.sv
// Final leading-one fix-up after the coarse (LZA / alignment) shift.
// The coarse shift can leave the leading one up to 3 positions below the MSB;
// this block shifts it the remaining distance and decrements the exponent.
//   n1_i   : coarsely shifted value
//   exp1_i : exponent matching n1_i (signed)
//   n2_o   : MSB-aligned value (n1_i << corr)
//   exp2_o : exp1_i - corr (signed)
module norm_lead_corr
  import fma_norm_pkg::*;
#(
  parameter int PRE_W  = calc_pre_w(23),
  parameter int EXP_W2 = 10
) (
  input  logic [PRE_W-1:0]         n1_i,
  input  logic signed [EXP_W2-1:0] exp1_i,
  output logic [PRE_W-1:0]         n2_o,
  output logic signed [EXP_W2-1:0] exp2_o
);

  logic [1:0]                corr;
  logic signed [EXP_W2-1:0]  corr_s;

  always_comb begin
    corr = 2'd3;
    unique casez (n1_i[PRE_W-1 -: 3])
      3'b1??:  corr = 2'd0;
      3'b01?:  corr = 2'd1;
      3'b001:  corr = 2'd2;
      default: corr = 2'd3;
    endcase
    corr_s = {{(EXP_W2-2){1'b0}}, corr};
    n2_o   = n1_i << corr;
    exp2_o = exp1_i - corr_s;
  end

endmodule

// File: rtl/normalize_pipe.sv
// Two-stage normalization pipeline for the FMA datapath.
// Stage 1 applies the coarse shift (alignment shift, or LZA shift when the
// alignment shift pushed the addend past the product window) and forms the
// provisional exponent. Stage 2 applies the final 0..3 bit leading-one
// correction, extracts the significand window and sticky bit, and clamps the
// exponent. Valid/ready handshake on both sides, 1 beat/cycle throughput.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   in_valid/ready   : input handshake
//   in_prenorm       : adder output before normalization
//   in_lza_shamt     : leading-zero-anticipator shift
//   in_shamt         : alignment shift
//   in_res_exp       : pre-normalization exponent
//   out_valid/ready  : output handshake
//   out_sig          : normalized significand, MSB-aligned
//   out_exp          : updated exponent (clamped)
//   out_exp_corr     : stage-1 result had a 0 MSB
//   out_sticky       : OR of bits below the out_sig window
//   out_zero         : input was exactly zero
//   out_uflow/oflow  : exponent clamped low / high
module normalize_pipe
  import fma_norm_pkg::*;
#(
  parameter  int SIG_WIDTH = 23,
  parameter  int EXP_WIDTH = 8,
  parameter  int SHAMT_W   = 6,
  localparam int PRE_W     = calc_pre_w(SIG_WIDTH),
  localparam int OUT_W     = calc_out_w(SIG_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PRE_W-1:0]     in_prenorm,
  input  logic [SHAMT_W-1:0]   in_lza_shamt,
  input  logic [SHAMT_W-1:0]   in_shamt,
  input  logic [EXP_WIDTH-1:0] in_res_exp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_sig,
  output logic [EXP_WIDTH-1:0] out_exp,
  output logic                 out_exp_corr,
  output logic                 out_sticky,
  output logic                 out_zero,
  output logic                 out_uflow,
  output logic                 out_oflow
);

  localparam int EW2   = EXP_WIDTH + 2;
  // Must hold the largest LZA-path shift: (2^SHAMT_W - 1) + SIG_WIDTH + 3.
  localparam int SH1_W = $clog2((1 << SHAMT_W) + SIG_WIDTH + 3) + 1;

  localparam logic signed [EW2-1:0] EXP_MAX_S = EW2'(exp_sat_max(EXP_WIDTH));
  localparam logic signed [EW2-1:0] ONE_S     = 1;
  localparam logic signed [EW2-1:0] THREE_S   = 3;

  // Clamp the signed exponent into the biased range; returns {uflow, oflow, exp}.
  function automatic logic [EXP_WIDTH+1:0] sat_exp(input logic signed [EW2-1:0] e,
                                                  input logic zero);
    logic                 uf;
    logic                 of;
    logic [EXP_WIDTH-1:0] ev;
    uf = 1'b0;
    of = 1'b0;
    ev = e[EXP_WIDTH-1:0];
    if (zero) begin
      ev = EXP_WIDTH'(EXP_ZERO);
    end else if (e <= 0) begin
      uf = 1'b1;
      ev = EXP_WIDTH'(EXP_ZERO);
    end else if (e >= EXP_MAX_S) begin
      of = 1'b1;
      ev = '1;
    end
    return {uf, of, ev};
  endfunction

  // Handshake / stage-valid state
  logic rdy_en_q;
  logic vld_p1_q, vld_p1_d;
  logic vld_p2_q, vld_p2_d;
  logic acc_p1, adv_p2;

  // Stage-1 registers
  logic [PRE_W-1:0]      n_p1_q, n_p1_d;
  logic signed [EW2-1:0] exp_p1_q, exp_p1_d;
  logic                  zero_p1_q, zero_p1_d;

  // Stage-2 (output) registers
  logic [OUT_W-1:0]     sig_p2_q, sig_p2_d;
  logic [EXP_WIDTH-1:0] exp_p2_q, exp_p2_d;
  logic                 corr_p2_q, corr_p2_d;
  logic                 sticky_p2_q, sticky_p2_d;
  logic                 zero_p2_q, zero_p2_d;
  logic                 uflow_p2_q, uflow_p2_d;
  logic                 oflow_p2_q, oflow_p2_d;

  logic                  big;
  logic [SH1_W-1:0]      shift1;
  logic signed [EW2-1:0] res_s, lza_s;
  logic [PRE_W-1:0]      n2;
  logic signed [EW2-1:0] exp2;
  logic [EXP_WIDTH+1:0]  sat;

  // rdy_en_q holds in_ready low during reset and for the first cycle after it.
  assign in_ready = rdy_en_q & (~vld_p1_q | ~vld_p2_q | out_ready);
  assign acc_p1   = in_valid & in_ready;
  assign adv_p2   = vld_p1_q & (~vld_p2_q | out_ready);

  always_comb begin
    vld_p1_d = vld_p1_q;
    if (acc_p1)      vld_p1_d = 1'b1;
    else if (adv_p2) vld_p1_d = 1'b0;
    vld_p2_d = vld_p2_q;
    if (adv_p2)         vld_p2_d = 1'b1;
    else if (out_ready) vld_p2_d = 1'b0;
  end

  // ---- Stage 1: coarse shift and provisional exponent ----
  always_comb begin
    big       = (SH1_W'(in_shamt) >= SH1_W'(OUT_W));
    shift1    = big ? SH1_W'(in_lza_shamt) + SH1_W'(SIG_WIDTH + 3) : SH1_W'(in_shamt);
    res_s     = EW2'(in_res_exp);
    lza_s     = EW2'(in_lza_shamt);
    exp_p1_d  = big ? res_s - lza_s + THREE_S : res_s + ONE_S;
    n_p1_d    = in_prenorm << shift1;
    zero_p1_d = (in_prenorm == '0);
  end

  // ---- Stage 2: leading-one correction, window extraction, clamp ----
  norm_lead_corr #(
    .PRE_W  (PRE_W),
    .EXP_W2 (EW2)
  ) u_lead_corr (
    .n1_i   (n_p1_q),
    .exp1_i (exp_p1_q),
    .n2_o   (n2),
    .exp2_o (exp2)
  );

  always_comb begin
    sat         = sat_exp(exp2, zero_p1_q);
    sig_p2_d    = zero_p1_q ? '0 : n2[PRE_W-1 -: OUT_W];
    sticky_p2_d = zero_p1_q ? 1'b0 : |n2[PRE_W-OUT_W-1:0];
    corr_p2_d   = ~n_p1_q[PRE_W-1];
    zero_p2_d   = zero_p1_q;
    uflow_p2_d  = sat[EXP_WIDTH+1];
    oflow_p2_d  = sat[EXP_WIDTH];
    exp_p2_d    = sat[EXP_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      n_p1_q      <= '0;
      exp_p1_q    <= '0;
      zero_p1_q   <= 1'b0;
      sig_p2_q    <= '0;
      exp_p2_q    <= '0;
      corr_p2_q   <= 1'b0;
      sticky_p2_q <= 1'b0;
      zero_p2_q   <= 1'b0;
      uflow_p2_q  <= 1'b0;
      oflow_p2_q  <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      if (acc_p1) begin
        n_p1_q    <= n_p1_d;
        exp_p1_q  <= exp_p1_d;
        zero_p1_q <= zero_p1_d;
      end
      if (adv_p2) begin
        sig_p2_q    <= sig_p2_d;
        exp_p2_q    <= exp_p2_d;
        corr_p2_q   <= corr_p2_d;
        sticky_p2_q <= sticky_p2_d;
        zero_p2_q   <= zero_p2_d;
        uflow_p2_q  <= uflow_p2_d;
        oflow_p2_q  <= oflow_p2_d;
      end
    end
  end

  assign out_valid    = vld_p2_q;
  assign out_sig      = sig_p2_q;
  assign out_exp      = exp_p2_q;
  assign out_exp_corr = corr_p2_q;
  assign out_sticky   = sticky_p2_q;
  assign out_zero     = zero_p2_q;
  assign out_uflow    = uflow_p2_q;
  assign out_oflow    = oflow_p2_q;

endmodule

// File: tb/tb_normalize_pipe.sv
// Self-checking bench for normalize_pipe: directed corner cases, an 8-beat
// stream under a toggling consumer, a mid-flight reset, and a randomized run
// checked against a behavioural model built from leading-zero counting.
module tb_normalize_pipe;

  localparam int PW = 80;
  localparam int OW = 27;

  typedef struct packed {
    logic [OW-1:0] sig;
    logic [7:0]    exp;
    logic          corr;
    logic          sticky;
    logic          zero;
    logic          uf;
    logic          of;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_prenorm = '0;
  logic [5:0]    in_lza_shamt = '0;
  logic [5:0]    in_shamt = '0;
  logic [7:0]    in_res_exp = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_sig;
  logic [7:0]    out_exp;
  logic          out_exp_corr, out_sticky, out_zero, out_uflow, out_oflow;

  normalize_pipe dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_prenorm   (in_prenorm),
    .in_lza_shamt (in_lza_shamt),
    .in_shamt     (in_shamt),
    .in_res_exp   (in_res_exp),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sig      (out_sig),
    .out_exp      (out_exp),
    .out_exp_corr (out_exp_corr),
    .out_sticky   (out_sticky),
    .out_zero     (out_zero),
    .out_uflow    (out_uflow),
    .out_oflow    (out_oflow)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   rcv     = 0;
  int   rdy_mode = 0;   // 0: hold 1, 1: toggle, 2: random, 3: hold 0
  res_t exp_q[$];
  int   cyc_q[$];
  res_t last_res;
  int   last_lat;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference: shift, count leading zeros, fix up at most 3 places, clamp.
  function automatic res_t model(input logic [PW-1:0] pre, input logic [5:0] lza,
                                 input logic [5:0] sh, input logic [7:0] rexp);
    res_t          r;
    int            shift, e, lz, corr;
    logic [PW-1:0] n1, n2;
    bit            found;
    if (int'(sh) >= 27) begin
      shift = int'(lza) + 26;
      e     = int'(rexp) - int'(lza) + 3;
    end else begin
      shift = int'(sh);
      e     = int'(rexp) + 1;
    end
    n1 = pre << shift;
    lz = PW;
    found = 0;
    for (int i = PW - 1; i >= 0; i--) begin
      if (!found && n1[i]) begin
        lz = PW - 1 - i;
        found = 1;
      end
    end
    corr = (lz < 3) ? lz : 3;
    n2 = n1 << corr;
    e  = e - corr;
    r.corr   = ~n1[PW-1];
    r.sig    = n2[PW-1 -: OW];
    r.sticky = |n2[PW-OW-1:0];
    r.zero   = 1'b0;
    r.uf     = 1'b0;
    r.of     = 1'b0;
    if (pre == '0) begin
      r.zero = 1'b1; r.exp = 8'd0; r.sig = '0; r.sticky = 1'b0;
    end else if (e <= 0) begin
      r.uf = 1'b1; r.exp = 8'd0;
    end else if (e >= 255) begin
      r.of = 1'b1; r.exp = 8'hff;
    end else begin
      r.exp = 8'(e);
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  res_t held;
  bit   stalled = 0;
  always @(negedge clk) begin
    res_t cur, want;
    if (!rst_n) begin
      stalled = 0;
    end else begin
      cur = '{sig: out_sig, exp: out_exp, corr: out_exp_corr, sticky: out_sticky,
              zero: out_zero, uf: out_uflow, of: out_oflow};
      if (out_valid && stalled) chk("hold_stable", 80'(cur), 80'(held));
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_prenorm, in_lza_shamt, in_shamt, in_res_exp));
        cyc_q.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 80'(out_valid), 80'(0));
        end else begin
          want = exp_q.pop_front();
          last_lat = cyc - cyc_q.pop_front();
          chk("sig",      80'(cur.sig),    80'(want.sig));
          chk("exp",      80'(cur.exp),    80'(want.exp));
          chk("exp_corr", 80'(cur.corr),   80'(want.corr));
          chk("sticky",   80'(cur.sticky), 80'(want.sticky));
          chk("zero",     80'(cur.zero),   80'(want.zero));
          chk("uflow",    80'(cur.uf),     80'(want.uf));
          chk("oflow",    80'(cur.of),     80'(want.of));
          last_res = cur;
          rcv++;
        end
      end
      stalled = out_valid && !out_ready;
      held = cur;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [PW-1:0] pre, input logic [5:0] lza,
                      input logic [5:0] sh, input logic [7:0] rexp);
    bit acc = 0;
    in_valid = 1'b1; in_prenorm = pre; in_lza_shamt = lza;
    in_shamt = sh;   in_res_exp = rexp;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    chk("accept", 80'(acc), 80'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !out_valid;
      @(posedge clk); #1;
    end
    chk("drain", 80'(done), 80'(1));
  endtask

  task automatic directed(input string tag, input logic [PW-1:0] pre, input logic [5:0] lza,
                          input logic [5:0] sh, input logic [7:0] rexp, input res_t want);
    send(pre, lza, sh, rexp);
    drain();
    chk({tag, "_res"}, 80'(last_res), 80'(want));
    chk({tag, "_lat"}, 80'(last_lat), 80'(2));
  endtask

  logic [PW-1:0] one = 80'd1;

  initial begin
    int r0;
    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_out_valid", 80'(out_valid), 80'(0));
    chk("rst_in_ready",  80'(in_ready),  80'(0));
    chk("rst_sig",       80'(out_sig),   80'(0));
    chk("rst_exp",       80'(out_exp),   80'(0));
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rel_in_ready0", 80'(in_ready), 80'(0));
    @(posedge clk); #1;
    chk("rel_in_ready1", 80'(in_ready), 80'(1));

    // Directed corner cases (out_ready held high)
    directed("msb79", one << 79, 6'd0, 6'd0, 8'd100,
             '{sig: 27'(1) << 26, exp: 8'd101, corr: 0, sticky: 0, zero: 0, uf: 0, of: 0});
    directed("msb77", one << 77, 6'd0, 6'd0, 8'd100,
             '{sig: 27'(1) << 26, exp: 8'd99, corr: 1, sticky: 0, zero: 0, uf: 0, of: 0});
    directed("bigsh", (one << 50) | one, 6'd0, 6'd27, 8'd100,
             '{sig: 27'(1) << 26, exp: 8'd100, corr: 1, sticky: 1, zero: 0, uf: 0, of: 0});
    directed("zero", '0, 6'd5, 6'd3, 8'd100,
             '{sig: '0, exp: 8'd0, corr: 1, sticky: 0, zero: 1, uf: 0, of: 0});
    directed("uflow", one << 77, 6'd0, 6'd0, 8'd1,
             '{sig: 27'(1) << 26, exp: 8'd0, corr: 1, sticky: 0, zero: 0, uf: 1, of: 0});
    directed("oflow", one << 79, 6'd0, 6'd0, 8'd254,
             '{sig: 27'(1) << 26, exp: 8'hff, corr: 0, sticky: 0, zero: 0, uf: 0, of: 1});
    directed("maxnorm", one << 79, 6'd0, 6'd0, 8'd253,
             '{sig: 27'(1) << 26, exp: 8'd254, corr: 0, sticky: 0, zero: 0, uf: 0, of: 0});
    directed("minnorm", one << 79, 6'd0, 6'd0, 8'd0,
             '{sig: 27'(1) << 26, exp: 8'd1, corr: 0, sticky: 0, zero: 0, uf: 0, of: 0});

    // 8-beat stream under a 1010 consumer
    rdy_mode = 1;
    r0 = rcv;
    for (int i = 0; i < 8; i++)
      send({$urandom, $urandom, 16'($urandom)} >> i, 6'($urandom_range(0, 63)),
           6'($urandom_range(0, 40)), 8'($urandom_range(0, 255)));
    drain();
    chk("stream_cnt", 80'(rcv - r0), 80'(8));

    // Reset with two beats in flight
    rdy_mode = 3;
    send(one << 79, 6'd0, 6'd0, 8'd50);
    send(one << 78, 6'd0, 6'd0, 8'd60);
    #2 rst_n = 1'b0;
    #1;
    chk("flight_out_valid", 80'(out_valid), 80'(0));
    chk("flight_in_ready",  80'(in_ready),  80'(0));
    chk("flight_sig",       80'(out_sig),   80'(0));
    exp_q.delete();
    cyc_q.delete();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale", 80'(out_valid), 80'(0));
      @(posedge clk); #1;
    end

    // Randomized traffic with random consumer back-pressure
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      logic [PW-1:0] p;
      p = {$urandom, $urandom, 16'($urandom)} >> $urandom_range(0, 80);
      send(p, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 40)),
           8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rdy_mode = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
